// File: rtl/rca_32bit_adder.sv
// Ripple-carry adder built from a chain of 1-bit full adders.
// The sum and carry-out are registered once at the end of the chain.

// One-bit full adder: the basic cell repeated along the carry chain.
module rca_full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    logic p;

    // The propagate term is shared by the sum and the carry-out.
    always_comb begin
        p   = a_i ^ b_i;
        s_o = p ^ c_i;
        c_o = (a_i & b_i) | (c_i & p);
    end

endmodule

// Top level: WIDTH cells in series, with the result registered.
module rca_32bit_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_start,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             carry_d;
    logic             carry_q;

    assign c[0] = carry_start;

    // Stage i takes its carry-in from stage i-1; there is no lookahead.
    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        rca_full_adder u_fa (
            .a_i (a[i]),
            .b_i (b[i]),
            .c_i (c[i]),
            .s_o (s[i]),
            .c_o (c[i+1])
        );
    end

    // Next-state values for the result registers.
    always_comb begin
        sum_d   = s;
        carry_d = c[WIDTH];
    end

    // The long ripple path ends here; reset discards any in-flight result.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign sum   = sum_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_rca_32bit_adder.sv
// Testbench for rca_32bit_adder: directed and random vectors
// checked against a queue of expected {carry,sum} results.

module tb_rca_32bit_adder;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         carry_start;
    logic [W-1:0] sum;
    logic         carry;

    int total;
    int bad;

    logic [W:0] exp_q[$];

    rca_32bit_adder #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .b           (b),
        .carry_start (carry_start),
        .sum         (sum),
        .carry       (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one vector, clock it in, then check the popped expectation.
    task automatic step(
        input string        tag,
        input logic         r,
        input logic [W-1:0] av,
        input logic [W-1:0] bv,
        input logic         cs
    );
        logic [W:0] e;
        logic [W:0] o;
        rst         = r;
        a           = av;
        b           = bv;
        carry_start = cs;
        if (r)
            exp_q.push_back('0);
        else
            exp_q.push_back({1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cs});
        @(posedge clk);
        #1;
        total++;
        o = {carry, sum};
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s got=%h exp=<empty queue>", tag, o);
        end else begin
            e = exp_q.pop_front();
            assert (o === e)
            else begin
                bad++;
                $error("FAIL %s got=%h exp=%h", tag, o, e);
            end
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        a           = '0;
        b           = '0;
        carry_start = 1'b0;
        @(negedge clk);

        step("rst0", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        step("rst1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        step("3p5", 1'b0, 32'h0000_0003, 32'h0000_0005, 1'b0);
        step("ripple", 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        step("ones_c", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        step("ones", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        step("msb", 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
        step("7f_p1", 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        step("zero", 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0);
        step("cs_only", 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1);
        step("alt", 1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
        step("rst_mid", 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        step("post_rst", 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);

        for (int i = 0; i < 60; i++) begin
            step(i == 30 ? "rand_rst" : "rand",
                 (i == 30) ? 1'b1 : 1'b0,
                 $urandom(), $urandom(), 1'($urandom_range(0, 1)));
        end

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $error("FAIL queue_drain got=%0d exp=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
